// File: rtl/ir_pkg.sv
// Shared definitions for the NEC infrared transmitter: state encoding,
// segment lengths in NEC time units and the frame packing helper.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_FIN        = 3'd6
  } tx_state_t;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int BIT0_SPACE_U = 1;
  localparam int BIT1_SPACE_U = 3;
  localparam int STOP_U       = 1;
  localparam int FRAME_BITS   = 32;

  // Sent LSB first, so addr bit 0 leaves the LED first.
  function automatic logic [31:0] nec_frame(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  function automatic logic is_mark(input tx_state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier for the IR LED. Forced low while disabled and
// restarts in its high phase on the first enabled cycle.
module ir_carrier_gen #(
  parameter int CARRIER_DIV = 658
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic carrier
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_en_d;
  logic          r_carrier;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_en_d    <= 1'b0;
      r_carrier <= 1'b0;
    end else begin
      r_en_d <= en;
      if (!en) begin
        r_carrier <= 1'b0;
        r_cnt     <= '0;
      end else if (!r_en_d) begin
        r_carrier <= 1'b1;
        r_cnt     <= '0;
      end else if (r_cnt == CW'(CARRIER_DIV - 1)) begin
        r_carrier <= ~r_carrier;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign carrier = r_carrier;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter: leader, 32 LSB-first data bits and a stop
// mark, with a carrier-modulated LED drive and a plain mark envelope.
module ir_nec_tx
  import ir_pkg::*;
#(
  parameter int UNIT_CYC    = 28125,
  parameter int CARRIER_DIV = 658
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic       abort,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam int CYC_W  = $clog2(UNIT_CYC);
  localparam int UNIT_W = 5;
  localparam int BIT_W  = 6;

  tx_state_t          r_state;
  logic [CYC_W-1:0]   r_cyc;
  logic [UNIT_W-1:0]  r_unit;
  logic [BIT_W-1:0]   r_bitcnt;
  logic [31:0]        r_shift;
  logic               r_busy;
  logic               r_done;
  logic               r_env;

  tx_state_t          w_state_nxt;
  logic [UNIT_W-1:0]  w_seg_units;
  logic               w_unit_end;
  logic               w_seg_end;
  logic               w_last_bit;
  logic               w_env_nxt;
  logic               w_carrier;

  always_comb begin
    w_seg_units = UNIT_W'(1);
    case (r_state)
      ST_LEAD_MARK:  w_seg_units = UNIT_W'(LEAD_MARK_U);
      ST_LEAD_SPACE: w_seg_units = UNIT_W'(LEAD_SPACE_U);
      ST_BIT_SPACE:  w_seg_units = r_shift[0] ? UNIT_W'(BIT1_SPACE_U) : UNIT_W'(BIT0_SPACE_U);
      ST_STOP_MARK:  w_seg_units = UNIT_W'(STOP_U);
      default:       w_seg_units = UNIT_W'(1);
    endcase

    w_unit_end = (r_cyc == CYC_W'(UNIT_CYC - 1));
    w_seg_end  = w_unit_end && (r_unit == (w_seg_units - UNIT_W'(1)));
    w_last_bit = (r_bitcnt == BIT_W'(FRAME_BITS - 1));

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (send && !abort) w_state_nxt = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (w_seg_end) w_state_nxt = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (w_seg_end) w_state_nxt = ST_BIT_MARK;
      ST_BIT_MARK:   if (w_seg_end) w_state_nxt = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (w_seg_end) w_state_nxt = w_last_bit ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (w_seg_end) w_state_nxt = ST_FIN;
      ST_FIN:        w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;

    w_env_nxt = is_mark(w_state_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cyc    <= '0;
      r_unit   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_env    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_FIN);
      r_env   <= w_env_nxt;

      // Timing counters restart at every segment boundary and idle at zero.
      if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
        r_cyc  <= '0;
        r_unit <= '0;
      end else if (w_unit_end) begin
        r_cyc  <= '0;
        r_unit <= r_unit + UNIT_W'(1);
      end else begin
        r_cyc <= r_cyc + CYC_W'(1);
      end

      if ((r_state == ST_IDLE) && (w_state_nxt == ST_LEAD_MARK)) begin
        r_shift  <= nec_frame(addr, cmd);
        r_bitcnt <= '0;
      end else if ((r_state == ST_BIT_SPACE) && w_seg_end) begin
        r_shift  <= {1'b0, r_shift[31:1]};
        r_bitcnt <= r_bitcnt + BIT_W'(1);
      end
    end
  end

  // The carrier is enabled from the next-cycle envelope so its register
  // lines up with r_env and is already zero outside marks.
  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .clk     (clk),
    .reset   (reset),
    .en      (w_env_nxt),
    .carrier (w_carrier)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign ir_env = r_env;
  assign ir_out = w_carrier;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx with UNIT_CYC = 4: decodes whole frames from
// the envelope and checks the carrier of a CARRIER_DIV = 1 and a = 2 instance.
module tb_ir_nec_tx;

  logic       clk;
  logic       reset;
  logic       send;
  logic       abort;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       busy, done, ir_env, ir_out;
  logic       busy2, done2, ir_env2, ir_out2;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int done_cnt = 0;
  int k1 = 0;
  int k2 = 0;

  ir_nec_tx #(.UNIT_CYC(4), .CARRIER_DIV(1)) dut (
    .clk(clk), .reset(reset), .send(send), .abort(abort), .addr(addr), .cmd(cmd),
    .busy(busy), .done(done), .ir_env(ir_env), .ir_out(ir_out)
  );

  ir_nec_tx #(.UNIT_CYC(4), .CARRIER_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .send(send), .abort(abort), .addr(addr), .cmd(cmd),
    .busy(busy2), .done(done2), .ir_env(ir_env2), .ir_out(ir_out2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Carrier model: mark-relative index k, DIV=1 alternates every cycle,
  // DIV=2 holds each level for two cycles; nothing may leak outside marks.
  always @(negedge clk) begin
    if (ir_env === 1'b1) begin
      chk("carrier_div1", {31'd0, ir_out}, {31'd0, (k1 % 2) == 0});
      k1++;
    end else begin
      chk("out_outside_mark1", {31'd0, ir_out}, 32'd0);
      k1 = 0;
    end
    if (ir_env2 === 1'b1) begin
      chk("carrier_div2", {31'd0, ir_out2}, {31'd0, ((k2 / 2) % 2) == 0});
      k2++;
    end else begin
      chk("out_outside_mark2", {31'd0, ir_out2}, 32'd0);
      k2 = 0;
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_send(input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    send = 1'b1;
    addr = a;
    cmd  = c;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic meas(input logic lvl, output int n);
    n = 0;
    while (ir_env === lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Starts at the negedge where ir_env is first high; returns at the FIN cycle.
  task automatic capture(output logic [31:0] bits, output int lhi, output int llo,
                         output int lat, output int bad);
    int t0, n, m;
    bits = '0;
    bad  = 0;
    n = 0;
    while (ir_env !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    meas(1'b1, lhi);
    meas(1'b0, llo);
    for (int i = 0; i < 32; i++) begin
      meas(1'b1, n);
      if (n != 4) bad++;
      meas(1'b0, m);
      if (m == 12) bits[i] = 1'b1;
      else if (m != 4) bad++;
    end
    meas(1'b1, n);
    if (n != 4) bad++;
    lat = (done === 1'b1) ? (cyc - t0) : -1;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input logic [31:0] frame);
    logic [31:0] bits;
    int lhi, llo, lat, bad;
    do_send(a, c);
    chk("env_rise", {31'd0, ir_env}, 32'd1);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    capture(bits, lhi, llo, lat, bad);
    chk("frame_bits", bits, frame);
    chk("lead_mark_len", lhi, 64);
    chk("lead_space_len", llo, 32);
    chk("bit_timing_errors", bad, 0);
    chk("done_latency", lat, 484);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic [31:0] frame;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] bits;
    int lhi, llo, lat, bad, dc0;

    vecs[0] = '{addr: 8'h00, cmd: 8'h00, frame: 32'hFF00_FF00};
    vecs[1] = '{addr: 8'h5A, cmd: 8'h3C, frame: 32'hC33C_A55A};
    vecs[2] = '{addr: 8'hFF, cmd: 8'h01, frame: 32'hFE01_00FF};
    vecs[3] = '{addr: 8'h12, cmd: 8'h34, frame: 32'hCB34_ED12};

    reset = 1'b0;
    send  = 1'b0;
    abort = 1'b0;
    addr  = 8'h00;
    cmd   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_env", {31'd0, ir_env}, 32'd0);
    chk("rst_out", {31'd0, ir_out}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].addr, vecs[v].cmd, vecs[v].frame);
      repeat (3) @(negedge clk);
    end

    // send together with abort in IDLE is ignored
    send  = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    send  = 1'b0;
    abort = 1'b0;
    chk("send_abort_busy", {31'd0, busy}, 32'd0);
    chk("send_abort_env", {31'd0, ir_env}, 32'd0);

    // abort in the mark of bit 10 (frame offset 192..195)
    dc0 = done_cnt;
    do_send(8'h00, 8'h00);
    repeat (193) @(negedge clk);
    chk("abort_in_mark", {31'd0, ir_env}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_env", {31'd0, ir_env}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", {31'd0, ir_out}, 32'd0);
    repeat (600) @(negedge clk);
    chk("abort_no_done", done_cnt, dc0);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    run_frame(8'h5A, 8'h3C, 32'hC33C_A55A);

    // second send and changed bytes during a frame are ignored
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    do_send(8'h5A, 8'h3C);
    fork
      capture(bits, lhi, llo, lat, bad);
      begin
        repeat (100) @(negedge clk);
        send = 1'b1;
        addr = 8'hFF;
        cmd  = 8'hFF;
        @(negedge clk);
        send = 1'b0;
        repeat (50) @(negedge clk);
        addr = 8'h00;
      end
    join
    chk("busy_send_frame", bits, 32'hC33C_A55A);
    chk("busy_send_latency", lat, 484);
    repeat (10) @(negedge clk);
    chk("busy_send_one_done", done_cnt, dc0 + 1);
    chk("busy_send_not_queued", {31'd0, busy}, 32'd0);

    // send held high: one IDLE cycle between frames
    @(negedge clk);
    addr = 8'h00;
    cmd  = 8'h00;
    send = 1'b1;
    @(negedge clk);
    capture(bits, lhi, llo, lat, bad);
    chk("b2b_frame", bits, 32'hFF00_FF00);
    chk("b2b_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("b2b_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("b2b_restart", {31'd0, ir_env}, 32'd1);
    send  = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("b2b_abort", {31'd0, busy}, 32'd0);

    // asynchronous reset during the leader mark
    repeat (2) @(negedge clk);
    do_send(8'h12, 8'h34);
    repeat (20) @(negedge clk);
    chk("pre_reset_env", {31'd0, ir_env}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_env", {31'd0, ir_env}, 32'd0);
    chk("async_rst_out", {31'd0, ir_out}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_frame(8'hFF, 8'h01, 32'hFE01_00FF);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
NEC-format infrared transmitter. It is the transmit-side counterpart of the IR receive controller.
- On a send request it latches an 8-bit address and command, then serialises a complete NEC frame: leader, 32 data bits, stop mark.
- Output is a carrier-modulated LED drive plus an unmodulated envelope.
- It reports completion with a one-cycle done pulse and supports abort mid-frame.

Parameters:
UNIT_CYC, 28125, clk cycles per 562.5 us NEC time unit (50 MHz clock); minimum 2.
CARRIER_DIV, 658, clk cycles per carrier half-period (~38 kHz at 50 MHz); minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
send  in  1  start request; sampled only in IDLE
abort  in  1  cancel current frame; highest priority after reset
addr  in  8  address byte; latched when send is accepted
cmd  in  8  command byte; latched when send is accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after a frame completes normally
ir_env  out  1  mark envelope: 1 during marks, 0 during spaces and idle
ir_out  out  1  ir_env AND carrier

Behaviour:
- Reset, asynchronous, while low:
  - state = IDLE
  - busy, done, ir_env, ir_out = 0
  - all counters and the shift register cleared
- Frame shift register, 32 bits, transmitted LSB first: {~cmd, cmd, ~addr, addr}. Bit 0 of addr goes out first.
- States:
  - IDLE
  - LEAD_MARK (16 units)
  - LEAD_SPACE (8 units)
  - BIT_MARK (1 unit)
  - BIT_SPACE (1 unit if bit = 0, 3 units if bit = 1)
  - STOP_MARK (1 unit)
  - FIN (1 clk cycle)
- Transitions:
  - IDLE -> LEAD_MARK when send = 1 and abort = 0; addr/cmd latched on the same edge.
  - LEAD_MARK -> LEAD_SPACE -> BIT_MARK, each on unit expiry.
  - BIT_MARK -> BIT_SPACE on unit expiry.
  - BIT_SPACE: on expiry, shift and increment the bit counter. If 32 bits have been sent go to STOP_MARK, else go to BIT_MARK.
  - STOP_MARK -> FIN on unit expiry.
  - FIN -> IDLE unconditionally; done = 1 during FIN only.
- Latency: send sampled high at edge N; ir_env rises in the cycle after edge N (registered state).
- Frame length is always 121 units, since complement bytes give exactly 16 ones and 16 zeros (24 + 16·2 + 16·4 + 1). done asserts exactly 121·UNIT_CYC cycles after ir_env first rises.
- Timing counters:
  - cyc_cnt counts 0..UNIT_CYC-1.
  - unit_cnt counts units within the current segment.
  - Both reset to 0 on every state change.
- Carrier:
  - carrier = 1 at the first cycle of each mark segment.
  - It toggles every CARRIER_DIV cycles.
  - It is forced to 0 outside marks.
- ir_env and ir_out are registered; no combinational path from inputs.
- abort = 1 in any non-IDLE state: next state IDLE, ir_env/ir_out = 0 from the following cycle, no done pulse.
- abort together with send in IDLE: send ignored.
- send while busy is ignored (not queued). addr/cmd changes while busy have no effect.
- send held high continuously: a new frame starts from the IDLE cycle after FIN, so back-to-back frames are separated by exactly one IDLE cycle.
- Unused state encodings go to IDLE (default branch).

Decomposition:
- Package ir_pkg:
  - tx state enum (2'b/3'b encoded, typed)
  - unit-count constants: LEAD_MARK_U = 16, LEAD_SPACE_U = 8, BIT0_SPACE_U = 1, BIT1_SPACE_U = 3, STOP_U = 1, FRAME_BITS = 32
- Sub-module ir_carrier_gen:
  - Parameter: CARRIER_DIV.
  - Inputs: clk, reset, en.
  - Output: carrier.
  - Restarts high when en rises.

Test Plan:
1. UNIT_CYC = 4, CARRIER_DIV = 1; send pulse with addr = 0x00, cmd = 0x00 -> ir_env high 64 cycles, low 32, then the bit pattern. done pulses exactly 484 cycles after ir_env rises, busy falls in the next cycle.
2. addr = 0x5A, cmd = 0x3C -> a bench decoder measuring space widths (4 cycles = 0, 12 cycles = 1) recovers 0x5A, 0xA5, 0x3C, 0xC3 LSB first.
3. abort asserted during bit 10 -> ir_env = 0 and busy = 0 one cycle later, no done. A subsequent send produces a full correct frame.
4. Second send pulse plus changed addr during a frame -> ignored; the frame completes with the original bytes, and exactly one done.
5. reset low mid LEAD_MARK -> all outputs 0 immediately (asynchronous). After release the block is IDLE and accepts a new send.
6. CARRIER_DIV = 2 during a 4-cycle mark -> ir_out = 1,1,0,0 aligned to mark start. ir_out is never 1 while ir_env = 0.
